// File: rtl/hash_row_splitter_pkg.sv
// rtl/hash_row_splitter_pkg.sv - shared widths, state encoding and bundle record for the row splitter
package hash_row_splitter_pkg;

    localparam int HASH_ISSUE_WIDTH      = 16;
    localparam int HASH_ISSUE_WIDTH_LOG2 = 4;
    localparam int ROW_SIZE              = 4;
    localparam int ADDR_WIDTH            = 32;
    localparam int META_MATCH_LEN_WIDTH  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]                                      head_addr;
        logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                       hist_valid;
        logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0]            hist_addr;
        logic [HASH_ISSUE_WIDTH*ROW_SIZE*META_MATCH_LEN_WIDTH-1:0]  meta_len;
        logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                       meta_can_ext;
        logic [HASH_ISSUE_WIDTH*8-1:0]                              data;
        logic                                                       delim;
    } bundle_t;

endpackage

// File: rtl/hash_row_splitter_lowest_set_bit_encoder.sv
// rtl/hash_row_splitter_lowest_set_bit_encoder.sv - find-first-set encoder giving index, any flag and one-hot
module lowest_set_bit_encoder #(
    parameter int W  = 16,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic [W-1:0]  onehot
);

    always_comb begin
        idx = '0;
        // Scanning downward lets the lowest set bit win the last assignment.
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IW'(i);
            end
        end
        any    = |mask;
        onehot = mask & (~mask + W'(1));
    end

endmodule

// File: rtl/hash_row_splitter.sv
// rtl/hash_row_splitter.sv - serializes a synchronized hash row bundle into per-lane beats for one match PE
module hash_row_splitter
    import hash_row_splitter_pkg::*;
(
    input  logic                                                       clk,
    input  logic                                                       rst_n,
    input  logic                                                       input_valid,
    input  logic [ADDR_WIDTH-1:0]                                      input_head_addr,
    input  logic [HASH_ISSUE_WIDTH-1:0]                                input_row_valid,
    input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                       input_history_valid_vec,
    input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0]            input_history_addr_vec,
    input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*META_MATCH_LEN_WIDTH-1:0]  input_meta_match_len_vec,
    input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                       input_meta_match_can_ext_vec,
    input  logic [HASH_ISSUE_WIDTH*8-1:0]                              input_data,
    input  logic                                                       input_delim,
    output logic                                                       input_ready,
    output logic                                                       output_valid,
    output logic [ADDR_WIDTH-1:0]                                      output_addr,
    output logic [HASH_ISSUE_WIDTH_LOG2-1:0]                           output_lane_idx,
    output logic [ROW_SIZE-1:0]                                        output_history_valid,
    output logic [ROW_SIZE*ADDR_WIDTH-1:0]                             output_history_addr,
    output logic [ROW_SIZE*META_MATCH_LEN_WIDTH-1:0]                   output_meta_match_len,
    output logic [ROW_SIZE-1:0]                                        output_meta_match_can_ext,
    output logic [7:0]                                                 output_data,
    output logic                                                       output_last,
    output logic                                                       output_delim,
    input  logic                                                       output_ready
);

    state_e                          state_q, state_d;
    logic [HASH_ISSUE_WIDTH-1:0]     pending_q, pending_d;
    logic                            delim_only_q, delim_only_d;
    bundle_t                         bundle_q, bundle_d;

    logic [HASH_ISSUE_WIDTH_LOG2-1:0] enc_idx;
    logic                             enc_any;
    logic [HASH_ISSUE_WIDTH-1:0]      enc_onehot;
    logic                             beat_last;
    logic [HASH_ISSUE_WIDTH_LOG2-1:0] lane;

    lowest_set_bit_encoder #(
        .W  (HASH_ISSUE_WIDTH),
        .IW (HASH_ISSUE_WIDTH_LOG2)
    ) u_lsb_enc (
        .mask   (pending_q),
        .idx    (enc_idx),
        .any    (enc_any),
        .onehot (enc_onehot)
    );

    // Exactly one pending bit means the lowest set bit is the whole mask.
    assign beat_last = delim_only_q || (pending_q == enc_onehot) || !enc_any;
    assign lane      = delim_only_q ? '0 : enc_idx;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        delim_only_d = delim_only_q;
        bundle_d     = bundle_q;
        input_ready  = 1'b0;
        output_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                input_ready = 1'b1;
                if (input_valid) begin
                    bundle_d.head_addr    = input_head_addr;
                    bundle_d.hist_valid   = input_history_valid_vec;
                    bundle_d.hist_addr    = input_history_addr_vec;
                    bundle_d.meta_len     = input_meta_match_len_vec;
                    bundle_d.meta_can_ext = input_meta_match_can_ext_vec;
                    bundle_d.data         = input_data;
                    bundle_d.delim        = input_delim;
                    pending_d             = input_row_valid;
                    delim_only_d          = (input_row_valid == '0);
                    // An empty bundle without a delimiter carries nothing worth a beat.
                    if ((input_row_valid != '0) || input_delim) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                output_valid = 1'b1;
                if (output_ready) begin
                    pending_d = pending_q & ~enc_onehot;
                    if (beat_last) begin
                        state_d      = S_IDLE;
                        pending_d    = '0;
                        delim_only_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                pending_d    = '0;
                delim_only_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        output_addr               = '0;
        output_lane_idx           = '0;
        output_history_valid      = '0;
        output_history_addr       = '0;
        output_meta_match_len     = '0;
        output_meta_match_can_ext = '0;
        output_data               = '0;
        output_last               = 1'b0;
        output_delim              = 1'b0;
        if (state_q == S_EMIT) begin
            output_lane_idx = lane;
            output_addr     = bundle_q.head_addr + ADDR_WIDTH'(lane);
            output_last     = beat_last;
            output_delim    = beat_last && bundle_q.delim;
            if (!delim_only_q) begin
                output_history_valid      = bundle_q.hist_valid[lane*ROW_SIZE +: ROW_SIZE];
                output_history_addr       = bundle_q.hist_addr[lane*ROW_SIZE*ADDR_WIDTH +: ROW_SIZE*ADDR_WIDTH];
                output_meta_match_len     = bundle_q.meta_len[lane*ROW_SIZE*META_MATCH_LEN_WIDTH +: ROW_SIZE*META_MATCH_LEN_WIDTH];
                output_meta_match_can_ext = bundle_q.meta_can_ext[lane*ROW_SIZE +: ROW_SIZE];
                output_data               = bundle_q.data[lane*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            delim_only_q <= 1'b0;
            bundle_q     <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            delim_only_q <= delim_only_d;
            bundle_q     <= bundle_d;
        end
    end

endmodule

// File: tb/tb_hash_row_splitter.sv
// tb/tb_hash_row_splitter.sv - directed self-checking bench for hash_row_splitter
module tb_hash_row_splitter;
    import hash_row_splitter_pkg::*;

    logic                                                       clk;
    logic                                                       rst_n;
    logic                                                       input_valid;
    logic [ADDR_WIDTH-1:0]                                      input_head_addr;
    logic [HASH_ISSUE_WIDTH-1:0]                                input_row_valid;
    logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                       input_history_valid_vec;
    logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0]            input_history_addr_vec;
    logic [HASH_ISSUE_WIDTH*ROW_SIZE*META_MATCH_LEN_WIDTH-1:0]  input_meta_match_len_vec;
    logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]                       input_meta_match_can_ext_vec;
    logic [HASH_ISSUE_WIDTH*8-1:0]                              input_data;
    logic                                                       input_delim;
    logic                                                       input_ready;
    logic                                                       output_valid;
    logic [ADDR_WIDTH-1:0]                                      output_addr;
    logic [HASH_ISSUE_WIDTH_LOG2-1:0]                           output_lane_idx;
    logic [ROW_SIZE-1:0]                                        output_history_valid;
    logic [ROW_SIZE*ADDR_WIDTH-1:0]                             output_history_addr;
    logic [ROW_SIZE*META_MATCH_LEN_WIDTH-1:0]                   output_meta_match_len;
    logic [ROW_SIZE-1:0]                                        output_meta_match_can_ext;
    logic [7:0]                                                 output_data;
    logic                                                       output_last;
    logic                                                       output_delim;
    logic                                                       output_ready;

    int checks;
    int errors;

    hash_row_splitter dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .input_valid                  (input_valid),
        .input_head_addr              (input_head_addr),
        .input_row_valid              (input_row_valid),
        .input_history_valid_vec      (input_history_valid_vec),
        .input_history_addr_vec       (input_history_addr_vec),
        .input_meta_match_len_vec     (input_meta_match_len_vec),
        .input_meta_match_can_ext_vec (input_meta_match_can_ext_vec),
        .input_data                   (input_data),
        .input_delim                  (input_delim),
        .input_ready                  (input_ready),
        .output_valid                 (output_valid),
        .output_addr                  (output_addr),
        .output_lane_idx              (output_lane_idx),
        .output_history_valid         (output_history_valid),
        .output_history_addr          (output_history_addr),
        .output_meta_match_len        (output_meta_match_len),
        .output_meta_match_can_ext    (output_meta_match_can_ext),
        .output_data                  (output_data),
        .output_last                  (output_last),
        .output_delim                 (output_delim),
        .output_ready                 (output_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle contents: lane i candidate j address = A000_0000 + 16*i + j,
    // meta len = (i+j)%8, can_ext = (i^j)&1, history_valid = i[3:0], data = 0x30+i.
    function automatic logic [ROW_SIZE*ADDR_WIDTH-1:0] exp_haddr(input int i);
        logic [ROW_SIZE*ADDR_WIDTH-1:0] r;
        for (int j = 0; j < ROW_SIZE; j++) r[j*ADDR_WIDTH +: ADDR_WIDTH] = 32'hA000_0000 + 32'(i*16 + j);
        return r;
    endfunction

    function automatic logic [ROW_SIZE*META_MATCH_LEN_WIDTH-1:0] exp_mlen(input int i);
        logic [ROW_SIZE*META_MATCH_LEN_WIDTH-1:0] r;
        for (int j = 0; j < ROW_SIZE; j++) r[j*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH] = 3'((i + j) % 8);
        return r;
    endfunction

    function automatic logic [ROW_SIZE-1:0] exp_ext(input int i);
        logic [ROW_SIZE-1:0] r;
        for (int j = 0; j < ROW_SIZE; j++) r[j] = 1'((i ^ j) & 1);
        return r;
    endfunction

    task automatic fill_bundle();
        for (int i = 0; i < HASH_ISSUE_WIDTH; i++) begin
            input_history_valid_vec[i*ROW_SIZE +: ROW_SIZE] = 4'(i);
            input_history_addr_vec[i*ROW_SIZE*ADDR_WIDTH +: ROW_SIZE*ADDR_WIDTH] = exp_haddr(i);
            input_meta_match_len_vec[i*ROW_SIZE*META_MATCH_LEN_WIDTH +: ROW_SIZE*META_MATCH_LEN_WIDTH] = exp_mlen(i);
            input_meta_match_can_ext_vec[i*ROW_SIZE +: ROW_SIZE] = exp_ext(i);
            input_data[i*8 +: 8] = 8'(8'h30 + i);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the first beat visible.
    task automatic send(input logic [31:0] head, input logic [15:0] rv, input logic delim);
        input_valid     = 1'b1;
        input_head_addr = head;
        input_row_valid = rv;
        input_delim     = delim;
        @(negedge clk);
        input_valid     = 1'b0;
        input_row_valid = '0;
        input_delim     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", output_valid); end
        checks++; if (output_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", output_addr); end
        checks++; if (output_last !== 1'b0 || output_delim !== 1'b0 || output_data !== 8'h0) begin
            errors++; $display("FAIL reset_data got last=%0b delim=%0b data=%h want 0", output_last, output_delim, output_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", input_ready); end
    endtask

    task automatic test_dense();
        send(32'h100, 16'hFFFF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++; if (output_valid !== 1'b1 || output_lane_idx !== 4'(i)) begin
                errors++; $display("FAIL dense_lane beat %0d got valid=%0b idx=%0d want 1 %0d", i, output_valid, output_lane_idx, i); end
            checks++; if (output_addr !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL dense_addr beat %0d got %h want %h", i, output_addr, 32'h100 + 32'(i)); end
            checks++; if (output_last !== (i == 15) || input_ready !== 1'b0) begin
                errors++; $display("FAIL dense_last beat %0d got last=%0b ready=%0b want %0b 0", i, output_last, input_ready, i == 15); end
            @(negedge clk);
        end
        checks++; if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            errors++; $display("FAIL dense_done got ready=%0b valid=%0b want 1 0", input_ready, output_valid); end
    endtask

    task automatic test_sparse();
        int lanes [4] = '{0, 5, 10, 15};
        send(32'h2000, 16'h8421, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int l = lanes[k];
            checks++; if (output_valid !== 1'b1 || output_lane_idx !== 4'(l) || output_addr !== 32'h2000 + 32'(l)) begin
                errors++; $display("FAIL sparse_lane beat %0d got idx=%0d addr=%h want %0d %h", k, output_lane_idx, output_addr, l, 32'h2000 + 32'(l)); end
            checks++; if (output_history_addr !== exp_haddr(l)) begin
                errors++; $display("FAIL sparse_haddr lane %0d got %h want %h", l, output_history_addr, exp_haddr(l)); end
            checks++; if (output_meta_match_len !== exp_mlen(l) || output_meta_match_can_ext !== exp_ext(l)) begin
                errors++; $display("FAIL sparse_meta lane %0d got %h/%h want %h/%h", l, output_meta_match_len, output_meta_match_can_ext, exp_mlen(l), exp_ext(l)); end
            checks++; if (output_history_valid !== 4'(l) || output_data !== 8'(8'h30 + l)) begin
                errors++; $display("FAIL sparse_hv lane %0d got hv=%h data=%h want %h %h", l, output_history_valid, output_data, 4'(l), 8'(8'h30 + l)); end
            checks++; if (output_last !== (k == 3)) begin
                errors++; $display("FAIL sparse_last lane %0d got %0b want %0b", l, output_last, k == 3); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [HASH_ISSUE_WIDTH*8-1:0] saved;
        saved = input_data;
        send(32'h300, 16'h0003, 1'b0);
        output_ready = 1'b0;
        input_data   = '1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (output_valid !== 1'b1 || output_lane_idx !== 4'd0 || output_addr !== 32'h300) begin
                errors++; $display("FAIL bp_hold cycle %0d got valid=%0b idx=%0d addr=%h want 1 0 300", c, output_valid, output_lane_idx, output_addr); end
            checks++; if (output_data !== 8'h30 || output_history_addr !== exp_haddr(0) || output_last !== 1'b0) begin
                errors++; $display("FAIL bp_fields cycle %0d got data=%h last=%0b want 30 0", c, output_data, output_last); end
            @(negedge clk);
        end
        output_ready = 1'b1;
        input_data   = saved;
        checks++; if (output_lane_idx !== 4'd0) begin
            errors++; $display("FAIL bp_release got idx=%0d want 0", output_lane_idx); end
        @(negedge clk);
        checks++; if (output_valid !== 1'b1 || output_lane_idx !== 4'd1 || output_addr !== 32'h301 || output_last !== 1'b1) begin
            errors++; $display("FAIL bp_lane1 got valid=%0b idx=%0d addr=%h last=%0b want 1 1 301 1", output_valid, output_lane_idx, output_addr, output_last); end
        @(negedge clk);
    endtask

    task automatic test_empty();
        send(32'h400, 16'h0000, 1'b1);
        checks++; if (output_valid !== 1'b1 || output_lane_idx !== 4'd0 || output_addr !== 32'h400) begin
            errors++; $display("FAIL empty_delim_beat got valid=%0b idx=%0d addr=%h want 1 0 400", output_valid, output_lane_idx, output_addr); end
        checks++; if (output_history_valid !== 4'h0 || output_data !== 8'h0 || output_last !== 1'b1 || output_delim !== 1'b1) begin
            errors++; $display("FAIL empty_delim_fields got hv=%h data=%h last=%0b delim=%0b want 0 0 1 1", output_history_valid, output_data, output_last, output_delim); end
        @(negedge clk);
        checks++; if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            errors++; $display("FAIL empty_delim_done got valid=%0b ready=%0b want 0 1", output_valid, input_ready); end
        send(32'h500, 16'h0000, 1'b0);
        for (int c = 0; c < 2; c++) begin
            checks++; if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
                errors++; $display("FAIL empty_drop cycle %0d got valid=%0b ready=%0b want 0 1", c, output_valid, input_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_delim();
        send(32'hFFFF_FFFE, 16'h000C, 1'b1);
        checks++; if (output_lane_idx !== 4'd2 || output_addr !== 32'h0 || output_last !== 1'b0 || output_delim !== 1'b0) begin
            errors++; $display("FAIL wrap_lane2 got idx=%0d addr=%h last=%0b delim=%0b want 2 0 0 0", output_lane_idx, output_addr, output_last, output_delim); end
        @(negedge clk);
        checks++; if (output_lane_idx !== 4'd3 || output_addr !== 32'h1 || output_last !== 1'b1 || output_delim !== 1'b1) begin
            errors++; $display("FAIL wrap_lane3 got idx=%0d addr=%h last=%0b delim=%0b want 3 1 1 1", output_lane_idx, output_addr, output_last, output_delim); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send(32'h600, 16'h00FF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (output_lane_idx !== 4'd2) begin
            errors++; $display("FAIL rstmid_pre got idx=%0d want 2", output_lane_idx); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (output_valid !== 1'b0 || output_addr !== 32'h0) begin
            errors++; $display("FAIL rstmid_drop got valid=%0b addr=%h want 0 0", output_valid, output_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle got ready=%0b valid=%0b want 1 0", input_ready, output_valid); end
        send(32'h40, 16'h0011, 1'b0);
        checks++; if (output_valid !== 1'b1 || output_lane_idx !== 4'd0 || output_addr !== 32'h40 || output_last !== 1'b0) begin
            errors++; $display("FAIL rstmid_next0 got idx=%0d addr=%h last=%0b want 0 40 0", output_lane_idx, output_addr, output_last); end
        @(negedge clk);
        checks++; if (output_lane_idx !== 4'd4 || output_addr !== 32'h44 || output_last !== 1'b1) begin
            errors++; $display("FAIL rstmid_next4 got idx=%0d addr=%h last=%0b want 4 44 1", output_lane_idx, output_addr, output_last); end
        @(negedge clk);
        checks++; if (output_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_end got valid=%0b want 0", output_valid); end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b0;
        input_valid     = 1'b0;
        input_head_addr = '0;
        input_row_valid = '0;
        input_delim     = 1'b0;
        output_ready    = 1'b1;
        input_history_valid_vec      = '0;
        input_history_addr_vec       = '0;
        input_meta_match_len_vec     = '0;
        input_meta_match_can_ext_vec = '0;
        input_data                   = '0;
        fill_bundle();
        @(negedge clk);
        test_reset();
        test_dense();
        test_sparse();
        test_backpressure();
        test_empty();
        test_wrap_delim();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_row_splitter.md
Name: hash_row_splitter

Overview:
- Reverse side of the post-hash row synchronization path.
- Accepts one synchronized row bundle: HASH_ISSUE_WIDTH lanes, each with ROW_SIZE history candidates plus meta-match info.
- Serializes the bundle into one per-lane beat for a single downstream match PE, skipping lanes whose row_valid bit is clear.
- Sits between the hash row synchronizer output stage and a per-lane match PE queue.

Parameters:
- HASH_ISSUE_WIDTH, 16, lanes per bundle.
- HASH_ISSUE_WIDTH_LOG2, 4, lane index width.
- ROW_SIZE, 4, history candidates per lane.
- ADDR_WIDTH, 32, byte address width.
- META_MATCH_LEN_WIDTH, 3, meta match length width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- input_valid  in  1  bundle valid
- input_head_addr  in  ADDR_WIDTH  address of lane 0
- input_row_valid  in  HASH_ISSUE_WIDTH  per-lane valid
- input_history_valid_vec  in  HASH_ISSUE_WIDTH*ROW_SIZE  candidate valids; lane i at [i*ROW_SIZE +: ROW_SIZE]
- input_history_addr_vec  in  HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH  candidate addresses
- input_meta_match_len_vec  in  HASH_ISSUE_WIDTH*ROW_SIZE*META_MATCH_LEN_WIDTH  meta lengths
- input_meta_match_can_ext_vec  in  HASH_ISSUE_WIDTH*ROW_SIZE  meta can-extend flags
- input_data  in  HASH_ISSUE_WIDTH*8  lane bytes; lane i at [i*8 +: 8]
- input_delim  in  1  end-of-block marker
- input_ready  out  1  bundle accept
- output_valid  out  1  lane beat valid
- output_addr  out  ADDR_WIDTH  head_addr + lane index
- output_lane_idx  out  HASH_ISSUE_WIDTH_LOG2  lane index
- output_history_valid  out  ROW_SIZE  lane candidate valids
- output_history_addr  out  ROW_SIZE*ADDR_WIDTH  lane candidate addresses
- output_meta_match_len  out  ROW_SIZE*META_MATCH_LEN_WIDTH  lane meta lengths
- output_meta_match_can_ext  out  ROW_SIZE  lane can-extend flags
- output_data  out  8  lane byte
- output_last  out  1  final beat of the bundle
- output_delim  out  1  input_delim of the bundle, asserted only with output_last
- output_ready  in  1  downstream accept

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-low reset rst_n.
- Reset state: state=S_IDLE, pending mask=0, output_valid=0, every data output=0. input_ready=1 once out of reset.
- Bundle register: captures the whole input bundle on the input handshake, using existing dff cells with enable. Pending mask is loaded with input_row_valid.
- State S_IDLE:
  - input_ready=1, output_valid=0.
  - On input_valid, capture the bundle. Then:
    - row_valid!=0: go to S_EMIT.
    - row_valid==0 and input_delim=1: go to S_EMIT in delim-only mode.
    - row_valid==0 and input_delim=0: drop the bundle, stay in S_IDLE.
- State S_EMIT:
  - input_ready=0, output_valid=1.
  - Current lane = lowest set bit of the pending mask, found by a find-first encoder.
  - Outputs are driven from the bundle register by the current lane.
  - output_last=1 when the pending mask has exactly one bit set (or in delim-only mode).
  - On output_ready, clear the current bit. If the beat was last, go to S_IDLE.
  - Without output_ready, every output holds stable.
- Delim-only beat: lane_idx=0, addr=head_addr, history_valid=0, data=0, last=1, delim=1.
- Latency and throughput:
  - First beat appears 1 cycle after the input handshake.
  - One beat per cycle while output_ready=1.
  - One idle cycle between bundles; no bypass path.
- Arithmetic: output_addr = head_addr + lane_idx modulo 2^ADDR_WIDTH; wrap-around is silent.
- Lane order: strictly ascending lane index.
- Candidate fields are passed through unmodified. A lane with row_valid=1 but history_valid=0 is still emitted.
- Reset asserted mid-bundle: remaining lanes are discarded and nothing is replayed. output_valid drops immediately (asynchronous).
- Unknown or illegal state encoding: return to S_IDLE.

Decomposition:
- Width constants (HASH_ISSUE_WIDTH, HASH_ISSUE_WIDTH_LOG2, ROW_SIZE, ADDR_WIDTH, META_MATCH_LEN_WIDTH) and the state encodings S_IDLE/S_EMIT go in the shared parameters.vh header.
- One sub-module, lowest_set_bit_encoder (parameter W):
  - Input: mask[W].
  - Outputs: idx[log2 W], any, onehot.
  - Reusable by other PE schedulers.

Test Plan:
- Dense bundle: row_valid=16'hFFFF, head_addr=0x100, output_ready=1 -> 16 beats, lane_idx 0..15, addr 0x100..0x10F, last only on lane 15; input_ready returns 1 on the cycle after the last beat.
- Sparse bundle: row_valid=16'h8421 -> beats for lanes 0,5,10,15 on consecutive cycles, addr head+0/5/10/15, last on lane 15; each lane's history_addr/meta fields match the source slice.
- Backpressure: row_valid=16'h0003, output_ready low for 3 cycles on the lane-0 beat -> all outputs held stable; lane 1 follows only after the handshake.
- Empty bundles: row_valid=0 with delim=1 -> one beat with lane_idx=0, history_valid=0, last=1, delim=1. row_valid=0 with delim=0 -> no output, input_ready stays 1.
- Wrap: head_addr=0xFFFFFFFE, row_valid=16'h000C -> addr 0x00000000 (lane 2) and 0x00000001 (lane 3).
- Reset mid-bundle: rst_n low after 2 of 8 beats -> output_valid=0 at once; after release input_ready=1 and the next bundle is emitted cleanly.
